// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core MEM
// stage and a debug/program-loader port.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_CORE | core owns the memory; debug wins when the core is idle or
//          | after losing STARVE_MAX consecutive cycles (reset state)
//   S_DBG  | debug owns the memory in a locked burst; core always stalled
//
// The core path is purely combinational (zero added latency). Debug reads
// return through a register one cycle after the grant.
module dmem_arbiter #(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int STARVE_MAX  = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  // core MEM-stage port
  input  logic                   c_req,
  input  logic                   c_we,
  input  logic [DM_ADDRESS-1:0]  c_addr,
  input  logic [DATA_W-1:0]      c_wdata,
  output logic [DATA_W-1:0]      c_rdata,
  output logic                   c_stall,
  // debug / loader port
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic                   d_lock,
  input  logic [DM_ADDRESS-1:0]  d_addr,
  input  logic [DATA_W-1:0]      d_wdata,
  output logic                   d_gnt,
  output logic                   d_rvalid,
  output logic [DATA_W-1:0]      d_rdata,
  // data memory
  output logic                   m_we,
  output logic                   m_re,
  output logic [DM_ADDRESS-1:0]  m_addr,
  output logic [DATA_W-1:0]      m_wdata,
  input  logic [DATA_W-1:0]      m_rdata,
  // performance
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [0:0] S_CORE = 1'b0;
  localparam logic [0:0] S_DBG  = 1'b1;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [SW-1:0] starve;
  logic          grant_d;
  logic          core_served;
  logic          starve_hit;

  assign starve_hit = (starve == STARVE_TOP);

  // Grant decision: core has priority in S_CORE unless debug has starved.
  always_comb begin
    grant_d     = 1'b0;
    core_served = 1'b0;
    if (state == S_CORE) begin
      grant_d     = d_req & (~c_req | starve_hit);
      core_served = c_req & ~grant_d;
    end else begin
      grant_d     = d_req;
      core_served = 1'b0;
    end
  end

  assign c_stall = c_req & ~core_served;
  assign d_gnt   = grant_d;
  assign c_rdata = m_rdata;

  // Memory mux; address and write data default to the core when idle.
  always_comb begin
    m_addr  = c_addr;
    m_wdata = c_wdata;
    m_we    = core_served & c_we;
    m_re    = core_served & ~c_we;
    if (grant_d) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_we    = d_we;
      m_re    = ~d_we;
    end
  end

  // Ownership transitions; a dropped d_req with d_lock held keeps S_DBG.
  always_comb begin
    state_nxt = state;
    case (state)
      S_CORE: begin
        if (grant_d & d_lock) state_nxt = S_DBG;
      end
      S_DBG: begin
        if (grant_d & ~d_lock)      state_nxt = S_CORE;
        else if (~d_req & ~d_lock)  state_nxt = S_CORE;
      end
      default: state_nxt = S_CORE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_CORE;
    else        state <= state_nxt;
  end

  // Starvation counter: counts debug losses to the core, clears on grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve <= '0;
    end else if (grant_d) begin
      starve <= '0;
    end else if ((state == S_CORE) && d_req && c_req && !starve_hit) begin
      starve <= starve + 1'b1;
    end
  end

  // Registered debug read response; d_rdata holds between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
    end else begin
      d_rvalid <= grant_d & ~d_we;
      if (grant_d && !d_we) d_rdata <= m_rdata;
    end
  end

  // Saturating count of core stall cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (c_stall && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural memory and a
// scoreboard queue for registered debug read responses.
module tb_dmem_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          c_req = 1'b0, c_we = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  logic [DW-1:0] c_rdata;
  logic          c_stall;
  logic          d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_we, m_re;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [15:0]   stall_cnt;

  // second instance with a narrow stall counter for the saturation case
  logic [DW-1:0] c_rdata2, d_rdata2, m_wdata2, m_rdata2;
  logic          c_stall2, d_gnt2, d_rvalid2, m_we2, m_re2;
  logic [AW-1:0] m_addr2;
  logic [3:0]    stall_cnt2;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .STARVE_MAX(SM), .STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_we(m_we), .m_re(m_re), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .stall_cnt(stall_cnt)
  );

  dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .STARVE_MAX(SM), .STALL_CNT_W(4)) dut2 (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata2), .c_stall(c_stall2),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt2), .d_rvalid(d_rvalid2), .d_rdata(d_rdata2),
    .m_we(m_we2), .m_re(m_re2), .m_addr(m_addr2), .m_wdata(m_wdata2), .m_rdata(m_rdata2),
    .stall_cnt(stall_cnt2)
  );

  assign m_rdata  = mem[m_addr];
  assign m_rdata2 = mem[m_addr2];

  always @(posedge clk) begin
    if (m_we) mem[m_addr] <= m_wdata;
  end

  // Scoreboard: every registered debug read response pops one expectation.
  always @(negedge clk) begin
    if (reset && d_rvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_rvalid: d_rdata=%h with no read outstanding", d_rdata);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (d_rdata !== e) begin
          errors++;
          $display("FAIL sb_rdata: got %h expected %h", d_rdata, e);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #1 reset = 1'b0;
    exp_q.delete();
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #2;
    checks++;
    if (d_rvalid !== 1'b0 || stall_cnt !== 16'd0 || stall_cnt2 !== 4'd0) begin
      errors++;
      $display("FAIL reset_regs: d_rvalid=%b stall_cnt=%0d stall_cnt2=%0d expected 0/0/0",
               d_rvalid, stall_cnt, stall_cnt2);
    end
    checks++;
    if (d_rdata !== 32'd0 || m_we !== 1'b0 || m_re !== 1'b0 || c_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: d_rdata=%h m_we=%b m_re=%b c_stall=%b expected 0",
               d_rdata, m_we, m_re, c_stall);
    end
    next_cycle();
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_core_alone();
    do_reset();
    c_req = 1'b1; c_we = 1'b1; c_addr = 9'd5; c_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (m_we !== 1'b1 || c_stall !== 1'b0 || m_addr !== 9'd5 || m_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL core_write: m_we=%b c_stall=%b m_addr=%0d m_wdata=%h expected 1/0/5/deadbeef",
               m_we, c_stall, m_addr, m_wdata);
    end
    next_cycle();
    c_we = 1'b0;
    @(negedge clk);
    checks++;
    if (c_rdata !== 32'hDEADBEEF || m_re !== 1'b1 || c_stall !== 1'b0) begin
      errors++;
      $display("FAIL core_read: c_rdata=%h m_re=%b c_stall=%b expected deadbeef/1/0",
               c_rdata, m_re, c_stall);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_debug_alone();
    idle_inputs();
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'd5;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || m_re !== 1'b1 || m_addr !== 9'd5) begin
      errors++;
      $display("FAIL dbg_grant: d_gnt=%b m_re=%b m_addr=%0d expected 1/1/5", d_gnt, m_re, m_addr);
    end
    exp_q.push_back(32'hDEADBEEF);
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL dbg_rvalid_c1: d_rvalid=%b d_rdata=%h expected 1/deadbeef", d_rvalid, d_rdata);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b0 || d_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL dbg_rvalid_c2: d_rvalid=%b d_rdata=%h expected 0/deadbeef (held)", d_rvalid, d_rdata);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    do_reset();
    c_req = 1'b1; c_we = 1'b0; c_addr = 9'd5;
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'd7; d_wdata = 32'h0000_1234;
    for (int cyc = 0; cyc <= SM + 1; cyc++) begin
      logic eg;
      eg = (cyc == SM);
      @(negedge clk);
      checks++;
      if (d_gnt !== eg || c_stall !== eg) begin
        errors++;
        $display("FAIL contention_c%0d: d_gnt=%b c_stall=%b expected %b/%b", cyc, d_gnt, c_stall, eg, eg);
      end
      if (eg) begin
        checks++;
        if (m_we !== 1'b1 || m_addr !== 9'd7 || m_wdata !== 32'h0000_1234) begin
          errors++;
          $display("FAIL contention_mux: m_we=%b m_addr=%0d m_wdata=%h expected 1/7/00001234",
                   m_we, m_addr, m_wdata);
        end
      end
      if (cyc == SM + 1) begin
        checks++;
        if (stall_cnt !== 16'd1 || c_rdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL contention_after: stall_cnt=%0d c_rdata=%h expected 1/deadbeef", stall_cnt, c_rdata);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  // Waits (bounded) for the first locked debug access to win against the core.
  task automatic wait_first_grant(input string nm, output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 10) begin
      @(negedge clk);
      if (d_gnt === 1'b1) ok = 1'b1;
      else begin
        next_cycle();
        n++;
      end
    end
    checks++;
    if (!ok || n != SM) begin
      errors++;
      $display("FAIL %s_grant_wait: granted=%b after %0d cycles expected 1 after %0d", nm, ok, n, SM);
    end
  endtask

  task automatic test_locked_burst();
    bit ok;
    do_reset();
    c_req = 1'b1; c_we = 1'b0; c_addr = 9'd5;
    d_req = 1'b1; d_we = 1'b1; d_lock = 1'b1; d_addr = 9'd1; d_wdata = 32'hA000_0001;
    wait_first_grant("burst", ok);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        d_addr  = AW'(k + 1);
        d_wdata = 32'hA000_0000 | DW'(k + 1);
        d_lock  = (k < 2);
        @(negedge clk);
      end
      checks++;
      if (d_gnt !== 1'b1 || c_stall !== 1'b1 || m_we !== 1'b1 || m_addr !== AW'(k + 1)) begin
        errors++;
        $display("FAIL burst_beat%0d: d_gnt=%b c_stall=%b m_we=%b m_addr=%0d expected 1/1/1/%0d",
                 k, d_gnt, c_stall, m_we, m_addr, k + 1);
      end
      next_cycle();
    end
    d_req = 1'b0; d_lock = 1'b0; d_we = 1'b0;
    @(negedge clk);
    checks++;
    if (c_stall !== 1'b0 || m_re !== 1'b1 || stall_cnt !== 16'd3) begin
      errors++;
      $display("FAIL burst_resume: c_stall=%b m_re=%b stall_cnt=%0d expected 0/1/3", c_stall, m_re, stall_cnt);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_back_to_back_reads();
    idle_inputs();
    for (int a = 1; a <= 3; a++) begin
      d_req = 1'b1; d_we = 1'b0; d_addr = AW'(a);
      @(negedge clk);
      checks++;
      if (d_gnt !== 1'b1) begin
        errors++;
        $display("FAIL b2b_grant%0d: d_gnt=%b expected 1", a, d_gnt);
      end
      exp_q.push_back(32'hA000_0000 | DW'(a));
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    next_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: %0d responses outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    do_reset();
    c_req = 1'b1; c_we = 1'b0; c_addr = 9'd5;
    d_req = 1'b1; d_we = 1'b0; d_lock = 1'b1; d_addr = 9'd1;
    wait_first_grant("rst", ok);
    exp_q.push_back(32'hA000_0001);
    next_cycle();
    d_addr = 9'd2;
    #2 reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_regs: d_rvalid=%b stall_cnt=%0d expected 0/0", d_rvalid, stall_cnt);
    end
    checks++;
    if (c_stall !== 1'b0 || d_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state: c_stall=%b d_gnt=%b expected 0/0 (core owns)", c_stall, d_gnt);
    end
    next_cycle();
    reset = 1'b1;
    d_req = 1'b0; d_lock = 1'b0;
    @(negedge clk);
    checks++;
    if (c_stall !== 1'b0 || m_re !== 1'b1 || c_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rst_release: c_stall=%b m_re=%b c_rdata=%h expected 0/1/deadbeef", c_stall, m_re, c_rdata);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_saturation();
    int bad;
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_lock = 1'b1; d_addr = 9'd9; d_wdata = 32'h5555_AAAA;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || c_stall !== 1'b0) begin
      errors++;
      $display("FAIL sat_enter: d_gnt=%b c_stall=%b expected 1/0", d_gnt, c_stall);
    end
    next_cycle();
    d_req = 1'b0; d_we = 1'b0; c_req = 1'b1; c_we = 1'b1; c_addr = 9'd5; c_wdata = 32'h0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (c_stall !== 1'b1 || m_we !== 1'b0 || m_re !== 1'b0 || d_gnt !== 1'b0) bad++;
      next_cycle();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_lock_idle: %0d cycles with c_stall!=1 or memory enabled, expected 0", bad);
    end
    d_lock = 1'b0;
    @(negedge clk);
    checks++;
    if (stall_cnt2 !== 4'hF || stall_cnt !== 16'd20) begin
      errors++;
      $display("FAIL sat_count: stall_cnt2=%h stall_cnt=%0d expected f/20", stall_cnt2, stall_cnt);
    end
    checks++;
    if (c_stall !== 1'b1) begin
      errors++;
      $display("FAIL sat_release_cycle: c_stall=%b expected 1", c_stall);
    end
    next_cycle();
    c_we = 1'b0;
    @(negedge clk);
    checks++;
    if (c_stall !== 1'b0 || stall_cnt2 !== 4'hF || stall_cnt !== 16'd21) begin
      errors++;
      $display("FAIL sat_resume: c_stall=%b stall_cnt2=%h stall_cnt=%0d expected 0/f/21",
               c_stall, stall_cnt2, stall_cnt);
    end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_core_alone();
    test_debug_alone();
    test_contention();
    test_locked_burst();
    test_back_to_back_reads();
    test_reset_mid_burst();
    test_saturation();
    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the pipeline MEM stage (core) and a debug/program-loader port. The core has priority and a same-cycle combinational path. The debug port gets a registered read response, a starvation guarantee, and an optional locked burst mode. It sits between the EXMEM stage outputs and the data memory, and drives a stall request into the hazard logic.

## Interface
- DM_ADDRESS, 9, data memory address width
- DATA_W, 32, data width
- STARVE_MAX, 4, max consecutive cycles a pending debug request may lose to the core (≥1)
- STALL_CNT_W, 16, width of the core-stall performance counter
- clk  in  1  global clock, rising edge
- reset  in  1  asynchronous, active-low reset
- c_req  in  1  core MEM-stage access request
- c_we  in  1  core write (1) / read (0)
- c_addr  in  DM_ADDRESS  core address
- c_wdata  in  DATA_W  core write data
- c_rdata  out  DATA_W  core read data, combinational from m_rdata
- c_stall  out  1  core request not served this cycle
- d_req  in  1  debug access request
- d_we  in  1  debug write/read
- d_lock  in  1  hold ownership after this access (burst)
- d_addr  in  DM_ADDRESS  debug address
- d_wdata  in  DATA_W  debug write data
- d_gnt  out  1  debug access performed this cycle
- d_rvalid  out  1  registered debug read data valid
- d_rdata  out  DATA_W  registered debug read data
- m_we, m_re  out  1 each  memory write/read enables
- m_addr  out  DM_ADDRESS  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data (combinational read)
- stall_cnt  out  STALL_CNT_W  saturating count of c_stall cycles

## Operation
- States: S_CORE (core owns; reset state) and S_DBG (debug owns, locked burst).
- starve: counter of width clog2(STARVE_MAX+1).
  - Increments in S_CORE when d_req & c_req and debug is not granted.
  - Saturates at STARVE_MAX.
  - Clears on any d_gnt.
- S_CORE grant rule: grant_d = d_req & (!c_req | starve==STARVE_MAX). Otherwise the core is served if c_req.
- S_DBG grant rule: grant_d = d_req. The core is never served in S_DBG.
- c_stall = c_req & !core_served.
- d_gnt = grant_d.
- Memory mux:
  - When debug is granted: m_addr/m_wdata/m_we/m_re come from the debug port.
  - Otherwise they come from the core port.
  - m_we = granted_req & we; m_re = granted_req & !we.
  - Both enables are 0 when nothing is granted. The address and write data still follow the core in that case.
- State transitions:
  - S_CORE→S_DBG on grant_d & d_lock.
  - S_DBG→S_CORE on grant_d & !d_lock (the last burst access).
  - S_DBG→S_CORE on !d_req & !d_lock.
  - S_DBG holds otherwise.
- Debug read response: on a granted debug read, d_rdata <= m_rdata and d_rvalid <= 1 at the next edge. In all other cycles d_rvalid <= 0. d_rdata holds its last value.
- stall_cnt increments by 1 on each cycle with c_stall=1 and saturates at all-ones.
- Simultaneous core and debug accesses to the same address are never issued together. Only the granted one reaches memory; the loser retries.

## Timing
- Reset (reset=0, asynchronous):
  - state=S_CORE, starve=0, d_rvalid=0, d_rdata=0, stall_cnt=0.
  - Combinational outputs follow the inputs under S_CORE rules.
- Core access: zero added latency. c_rdata is valid in the same cycle the core is served.
- Debug access:
  - d_gnt is asserted in the request cycle.
  - A write commits at that clock edge.
  - Read data appears with d_rvalid=1 exactly one cycle after d_gnt.
- Worst-case debug wait with the core requesting continuously: STARVE_MAX cycles. The grant occurs in cycle STARVE_MAX counted from request assertion at cycle 0.
- Burst: back-to-back debug accesses at one per cycle with no bubbles. The core may resume in the cycle after the unlocked final access.
- Reset asserted mid-burst or with d_rvalid pending: immediate return to reset values. The pending response is dropped.
- d_req deasserted in S_DBG while d_lock=1: ownership is kept, the core stays stalled, and memory enables are 0.

## Test plan
- Core alone:
  - Stimulus: c_req=1, c_we=1, addr 5, data 0xDEADBEEF.
  - Response: m_we=1 same cycle, c_stall=0.
  - Follow-up read of addr 5: c_rdata=0xDEADBEEF same cycle.
- Debug alone:
  - Stimulus: read of addr 5.
  - Response: d_gnt=1 in cycle 0; d_rvalid=1 and d_rdata=0xDEADBEEF in cycle 1; d_rvalid=0 in cycle 2.
- Contention, STARVE_MAX=4:
  - Stimulus: c_req and d_req held high.
  - Response: core served in cycles 0–3; cycle 4 has d_gnt=1, c_stall=1, and stall_cnt becomes 1; starve=0 afterwards; the core is served again in cycle 5.
- Locked burst:
  - Stimulus: three debug writes (addr 1,2,3), d_lock=1,1,0, c_req=1 throughout.
  - Response: c_stall=1 for 3 cycles; the core is served in the 4th cycle; stall_cnt=3.
- Reset mid-burst:
  - Stimulus: reset driven low in the 2nd burst cycle.
  - Response: asynchronous return to S_CORE, d_rvalid=0, stall_cnt=0. After release, c_req is served with c_stall=0.
- Counter saturation:
  - Stimulus: STALL_CNT_W=4, core stalled for 20 cycles.
  - Response: stall_cnt stops at 0xF.
